// File: rtl/crc_serial_encoder_ctrl.sv
// Bit-serial CRC encoder with sequencing controller and a one-entry request buffer.
// Shifts each word MSB-first through the CRC, then emits one memory write of {data, crc}.
module crc_serial_encoder_ctrl #(
    parameter int                 DATA_W   = 8,
    parameter int                 CRC_W    = 4,
    parameter int                 ADDR_W   = 4,
    parameter logic [CRC_W-1:0]   POLY     = 4'h3,
    parameter logic [CRC_W-1:0]   CRC_INIT = 4'h0,
    parameter logic [CRC_W-1:0]   XOR_OUT  = 4'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [ADDR_W-1:0]         addr_in,
    output logic                      ready,
    output logic                      busy,
    output logic                      mem_we,
    output logic [DATA_W+CRC_W-1:0]   mem_data,
    output logic [ADDR_W-1:0]         mem_addr
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } state_t;

    // One MSB-first CRC step for a single message bit.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic bit_in);
        logic fb;
        fb       = crc[CRC_W-1] ^ bit_in;
        crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

    state_t                  state_r;
    logic [DATA_W-1:0]       sreg_r;
    logic [DATA_W-1:0]       data_r;
    logic [ADDR_W-1:0]       addr_r;
    logic [CRC_W-1:0]        crc_r;
    logic [CNT_W-1:0]        count_r;
    logic                    pend_valid_r;
    logic [DATA_W-1:0]       pend_data_r;
    logic [ADDR_W-1:0]       pend_addr_r;
    logic                    mem_we_r;
    logic [DATA_W+CRC_W-1:0] mem_data_r;
    logic [ADDR_W-1:0]       mem_addr_r;

    logic                    accept_s;
    logic                    last_bit_s;
    logic [CRC_W-1:0]        crc_next_s;
    logic                    load_en_s;
    logic [DATA_W-1:0]       load_data_s;
    logic [ADDR_W-1:0]       load_addr_s;

    assign ready      = !pend_valid_r;
    assign busy       = (state_r != IDLE) || pend_valid_r;
    assign mem_we     = mem_we_r;
    assign mem_data   = mem_data_r;
    assign mem_addr   = mem_addr_r;

    assign accept_s   = write && !pend_valid_r;
    assign last_bit_s = (count_r == CNT_W'(DATA_W - 1));
    assign crc_next_s = crc_step(crc_r, sreg_r[DATA_W-1]);

    // Select the source of the next word: the pending entry has priority in WRITE.
    always_comb begin
        load_en_s   = 1'b0;
        load_data_s = data_in;
        load_addr_s = addr_in;
        case (state_r)
            IDLE: begin
                load_en_s = accept_s;
            end
            WRITE: begin
                if (pend_valid_r) begin
                    load_en_s   = 1'b1;
                    load_data_s = pend_data_r;
                    load_addr_s = pend_addr_r;
                end else begin
                    load_en_s   = write;
                end
            end
            default: begin
                load_en_s = 1'b0;
            end
        endcase
    end

    // Controller, CRC datapath, pending buffer and registered memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            sreg_r       <= {DATA_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            crc_r        <= CRC_INIT;
            count_r      <= {CNT_W{1'b0}};
            pend_valid_r <= 1'b0;
            pend_data_r  <= {DATA_W{1'b0}};
            pend_addr_r  <= {ADDR_W{1'b0}};
            mem_we_r     <= 1'b0;
            mem_data_r   <= {(DATA_W+CRC_W){1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= load_en_s ? SHIFT : IDLE;
                end
                SHIFT: begin
                    crc_r  <= crc_next_s;
                    sreg_r <= {sreg_r[DATA_W-2:0], 1'b0};
                    if (accept_s) begin
                        pend_valid_r <= 1'b1;
                        pend_data_r  <= data_in;
                        pend_addr_r  <= addr_in;
                    end
                    if (last_bit_s) begin
                        state_r    <= WRITE;
                        mem_we_r   <= 1'b1;
                        mem_data_r <= {data_r, crc_next_s ^ XOR_OUT};
                        mem_addr_r <= addr_r;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                WRITE: begin
                    state_r <= load_en_s ? SHIFT : IDLE;
                    if (pend_valid_r) begin
                        pend_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            if (load_en_s) begin
                sreg_r  <= load_data_s;
                data_r  <= load_data_s;
                addr_r  <= load_addr_s;
                crc_r   <= CRC_INIT;
                count_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_crc_serial_encoder_ctrl.sv
// Randomised bench for crc_serial_encoder_ctrl: two instances (default and inverted init/xor)
// checked against a transaction-level timing model and a polynomial-division CRC model.
module tb_crc_serial_encoder_ctrl;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [3:0]  addr_in = 4'h0;
    logic        ready, busy, mem_we;
    logic [11:0] mem_data;
    logic [3:0]  mem_addr;
    logic        ready2, busy2, mem_we2;
    logic [11:0] mem_data2;
    logic [3:0]  mem_addr2;

    crc_serial_encoder_ctrl dut (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .addr_in(addr_in),
        .ready(ready), .busy(busy), .mem_we(mem_we), .mem_data(mem_data), .mem_addr(mem_addr)
    );

    crc_serial_encoder_ctrl #(.CRC_INIT(4'hF), .XOR_OUT(4'hF)) dut2 (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .addr_in(addr_in),
        .ready(ready2), .busy(busy2), .mem_we(mem_we2), .mem_data(mem_data2), .mem_addr(mem_addr2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         a;
        int         l;
        int         w;
        logic [7:0] d;
        logic [3:0] ad;
    } rec_t;

    rec_t        q[$];
    int          edge_n = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        in_reset = 1'b0;
    logic [11:0] last_data, last_data2;
    logic [3:0]  last_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // Remainder of (init*x^8 + d*x^4) mod (x^4+x+1), then output xor.
    function automatic logic [3:0] ref_crc(input logic [7:0] d, input logic [3:0] init,
                                           input logic [3:0] xo);
        logic [15:0] v;
        v = ({12'h000, init} << 8) ^ ({8'h00, d} << 4);
        for (int i = 15; i >= 4; i--) begin
            if (v[i]) v = v ^ (16'h0013 << (i - 4));
        end
        return v[3:0] ^ xo;
    endfunction

    task automatic check_edge();
        logic       exp_we, exp_rdy, exp_busy;
        logic [7:0] ed;
        logic [3:0] ea;
        int         t;
        t = edge_n; exp_we = 1'b0; exp_rdy = 1'b1; exp_busy = 1'b0; ed = 8'h00; ea = 4'h0;
        foreach (q[k]) begin
            if (q[k].w == t) begin exp_we = 1'b1; ed = q[k].d; ea = q[k].ad; end
            if (q[k].a <= t && t < q[k].l) exp_rdy = 1'b0;
            if (q[k].a <= t && t <= q[k].w) exp_busy = 1'b1;
        end
        check_eq("ready", 32'(ready), 32'(exp_rdy));
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("mem_we", 32'(mem_we), 32'(exp_we));
        check_eq("ready2", 32'(ready2), 32'(exp_rdy));
        check_eq("busy2", 32'(busy2), 32'(exp_busy));
        check_eq("mem_we2", 32'(mem_we2), 32'(exp_we));
        if (exp_we) begin
            check_eq("mem_data", 32'(mem_data), 32'({ed, ref_crc(ed, 4'h0, 4'h0)}));
            check_eq("mem_addr", 32'(mem_addr), 32'(ea));
            check_eq("mem_data2", 32'(mem_data2), 32'({ed, ref_crc(ed, 4'hF, 4'hF)}));
            check_eq("mem_addr2", 32'(mem_addr2), 32'(ea));
            last_data = mem_data; last_data2 = mem_data2; last_addr = mem_addr;
        end
        if (in_reset) begin
            check_eq("rst_mem_data", 32'(mem_data), 32'h0);
            check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        end
        while (q.size() > 0 && q[0].w < t) void'(q.pop_front());
    endtask

    // One clock: drive at the falling edge, update the model, check after the rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic [3:0] a,
                        input logic r, output logic acc);
        rec_t rc;
        @(negedge clk);
        write = w; data_in = d; addr_in = a; rst = r; in_reset = r;
        acc = w && (ready === 1'b1) && !r;
        if (r) begin
            q.delete();
        end else if (acc) begin
            rc.a  = edge_n + 1;
            rc.l  = (q.size() == 0 || rc.a > q[$].w) ? rc.a : q[$].w + 1;
            rc.w  = rc.l + DW;
            rc.d  = d;
            rc.ad = a;
            q.push_back(rc);
        end
        @(posedge clk);
        edge_n++;
        #1;
        check_edge();
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 4'($urandom), 1'b0, acc);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] a);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, d, a, 1'b0, acc);
        if (!acc) check_eq("accept_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        logic acc;
        step(1'b0, 8'h00, 4'h0, 1'b1, acc);
        step(1'b0, 8'h00, 4'h0, 1'b1, acc);
        idle(1);

        send(8'hA5, 4'd2);
        idle(10);
        check_eq("a5_data", 32'(last_data), 32'h0A5B);
        check_eq("a5_addr", 32'(last_addr), 32'h2);
        send(8'h13, 4'd4);
        idle(10);
        check_eq("13_data", 32'(last_data), 32'h0130);
        send(8'h8B, 4'd6);
        idle(10);
        check_eq("8b_data", 32'(last_data), 32'h08B0);

        // Buffered second request and a held third one.
        send(8'hA5, 4'd2);
        idle(2);
        send(8'h13, 4'd4);
        send(8'h8B, 4'd6);
        idle(30);
        check_eq("b2b_last", 32'(last_data), 32'h08B0);

        // Reset in the middle of a word with the pending slot full.
        send(8'hA5, 4'd2);
        idle(1);
        send(8'h13, 4'd4);
        idle(2);
        step(1'b0, 8'h00, 4'h0, 1'b1, acc);
        idle(12);
        send(8'h8B, 4'd6);
        idle(10);
        check_eq("post_rst_data", 32'(last_data), 32'h08B0);
        check_eq("post_rst_addr", 32'(last_addr), 32'h6);

        send(8'h00, 4'd1);
        idle(10);
        check_eq("init_xor_zero", 32'(last_data2), 32'({8'h00, ref_crc(8'h00, 4'hF, 4'hF)}));

        for (int i = 0; i < 256; i++) begin
            idle(int'($urandom_range(0, 3)));
            send(8'(i), 4'($urandom));
        end
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
